// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Update-side companion to the 2-bit branch predictor table. Every issued
// prediction (table index + predicted direction) is recorded in program order.
// When the oldest branch resolves, its record is popped and the table's update
// interface is driven one cycle later with the index, the actual outcome and a
// one-cycle enable strobe. Mispredictions are flagged with a one-cycle strobe
// and counted in a saturating performance counter.
//
// Ports
//   clk             single clock, rising edge
//   rst_n           asynchronous reset, active low
//   pred_valid      a prediction was issued this cycle
//   pred_addr       table index used for that prediction
//   pred_taken      predicted direction (1 = taken)
//   pred_ready      a record can be accepted (= !full)
//   res_valid       oldest in-flight branch resolved this cycle
//   res_taken       actual outcome (1 = taken)
//   res_ready       a record is available to resolve (= !empty)
//   flush           discard all in-flight records
//   upd_enable      one-cycle strobe to the table's update enable
//   upd_addr        table index to update (holds between strobes)
//   upd_taken       outcome to train with (holds between strobes)
//   mispredict      one-cycle strobe, resolved branch was mispredicted
//   count           current occupancy
//   mispredict_cnt  mispredicts since reset, saturating
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [ADDR_W-1:0]        pred_addr,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  input  logic                     flush,
  output logic                     upd_enable,
  output logic [ADDR_W-1:0]        upd_addr,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // Record storage. Kept out of the reset domain so it can map onto
  // distributed/block RAM; validity is governed entirely by the pointers.
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic              r_mem_pred [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              r_upd_enable;
  logic [ADDR_W-1:0] r_upd_addr;
  logic              r_upd_taken;
  logic              r_mispredict;
  logic [CNT_W-1:0]  r_mispredict_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_pred;
  logic              w_mis;

  // Ready flags depend only on registered occupancy, never on the opposite
  // side's valid, so a full queue refuses a push even while popping.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);

  // Flush squashes both sides in the same cycle.
  assign w_push = pred_valid && !w_full  && !flush;
  assign w_pop  = res_valid  && !w_empty && !flush;

  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_head_pred = r_mem_pred[r_rd_ptr];
  assign w_mis       = (res_taken != w_head_pred);

  // ---------------------------------------------------------------------------
  // Storage write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= pred_addr;
      r_mem_pred[r_wr_ptr] <= pred_taken;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered update interface and mispredict accounting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_enable     <= 1'b0;
      r_upd_addr       <= '0;
      r_upd_taken      <= 1'b0;
      r_mispredict     <= 1'b0;
      r_mispredict_cnt <= '0;
    end else if (w_pop) begin
      r_upd_enable <= 1'b1;
      r_upd_addr   <= w_head_addr;
      r_upd_taken  <= res_taken;
      r_mispredict <= w_mis;
      // Saturate at all-ones rather than wrapping.
      if (w_mis && (r_mispredict_cnt != '1)) begin
        r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
      end
    end else begin
      // Strobes drop; addr/taken hold so the table sees stable data.
      r_upd_enable <= 1'b0;
      r_mispredict <= 1'b0;
    end
  end

  assign pred_ready     = !w_full;
  assign res_ready      = !w_empty;
  assign count          = r_count;
  assign upd_enable     = r_upd_enable;
  assign upd_addr       = r_upd_addr;
  assign upd_taken      = r_upd_taken;
  assign mispredict     = r_mispredict;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Scoreboard bench: each stimulus cycle that pops a record pushes the expected
// update (addr, taken, mispredict, counter) into a queue; a monitor on the
// falling edge pops and compares whenever upd_enable is seen. Directed checks
// cover occupancy, ready flags, flush and asynchronous reset behaviour.
// Built with CNT_W=4 so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              pred_valid;
  logic [ADDR_W-1:0] pred_addr;
  logic              pred_taken;
  logic              pred_ready;
  logic              res_valid;
  logic              res_taken;
  logic              res_ready;
  logic              flush;
  logic              upd_enable;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_taken;
  logic              mispredict;
  logic [3:0]        count;
  logic [CNT_W-1:0]  mispredict_cnt;

  branch_resolve_queue #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_valid    (pred_valid),
    .pred_addr     (pred_addr),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_ready     (res_ready),
    .flush         (flush),
    .upd_enable    (upd_enable),
    .upd_addr      (upd_addr),
    .upd_taken     (upd_taken),
    .mispredict    (mispredict),
    .count         (count),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              taken;
    logic              mis;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              pred;
  } rec_t;

  exp_t             exp_q[$];
  rec_t             mdl_q[$];
  logic [CNT_W-1:0] mdl_cnt;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock of stimulus; expected updates are queued before the edge.
  task automatic step(input logic pv, input logic [ADDR_W-1:0] pa, input logic pt,
                      input logic rv, input logic rt, input logic fl);
    bit   do_push;
    bit   do_pop;
    rec_t head;
    exp_t e;
    do_push = pv && (mdl_q.size() < DEPTH) && !fl;
    do_pop  = rv && (mdl_q.size() > 0) && !fl;
    if (fl) begin
      mdl_q.delete();
    end else begin
      if (do_pop) begin
        head   = mdl_q.pop_front();
        e.addr = head.addr;
        e.taken = rt;
        e.mis  = (head.pred != rt);
        if (e.mis && (mdl_cnt != '1)) mdl_cnt = mdl_cnt + 1'b1;
        e.cnt  = mdl_cnt;
        exp_q.push_back(e);
      end
      if (do_push) mdl_q.push_back('{addr: pa, pred: pt});
    end
    pred_valid = pv; pred_addr = pa; pred_taken = pt;
    res_valid = rv;  res_taken = rt; flush = fl;
    @(posedge clk);
    #1;
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
  endtask

  // Monitor: compare every presented update against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (upd_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_upd", 32'(upd_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("upd addr=%02h taken=%0b mis=%0b cnt=%0d", upd_addr, upd_taken, mispredict, mispredict_cnt);
          check("upd_addr", 32'(upd_addr), 32'(e.addr));
          check("upd_taken", 32'(upd_taken), 32'(e.taken));
          check("mispredict", 32'(mispredict), 32'(e.mis));
          check("mispredict_cnt", 32'(mispredict_cnt), 32'(e.cnt));
        end
      end else if (mispredict) begin
        check("mis_without_upd", 32'(mispredict), 32'd0);
      end
    end
  end

  logic [CNT_W-1:0] saved_cnt;

  initial begin
    rst_n = 1'b0;
    pred_valid = 1'b0; pred_addr = '0; pred_taken = 1'b0;
    res_valid = 1'b0;  res_taken = 1'b0; flush = 1'b0;
    mdl_cnt = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_pred_ready", 32'(pred_ready), 32'd1);
    check("rst_res_ready", 32'(res_ready), 32'd0);
    check("rst_upd_enable", 32'(upd_enable), 32'd0);
    check("rst_mcnt", 32'(mispredict_cnt), 32'd0);

    // Three records, resolved T,T,T back-to-back: mispredict 0,1,0
    step(1, 8'h12, 1, 0, 0, 0);
    step(1, 8'h34, 0, 0, 0, 0);
    step(1, 8'h56, 1, 0, 0, 0);
    check("t1_count3", 32'(count), 32'd3);
    step(0, 8'h00, 0, 1, 1, 0);
    step(0, 8'h00, 0, 1, 1, 0);
    step(0, 8'h00, 0, 1, 1, 0);
    @(posedge clk); #1;
    check("t1_count0", 32'(count), 32'd0);
    check("t1_mcnt", 32'(mispredict_cnt), 32'd1);

    // Fill to DEPTH, extra push refused, pop with push refused
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 1, 0, 0, 0);
    check("t2_full_count", 32'(count), 32'd8);
    check("t2_full_ready", 32'(pred_ready), 32'd0);
    step(1, 8'hEE, 1, 0, 0, 0);
    check("t2_extra_ignored", 32'(count), 32'd8);
    step(1, 8'hEF, 1, 1, 1, 0);
    check("t2_pop_count", 32'(count), 32'd7);
    check("t2_pop_ready", 32'(pred_ready), 32'd1);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 0, 1, 1, 0);
    check("t2_drained", 32'(count), 32'd0);

    // Steady-state push+pop at count=3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'h43 + i), 8'(i)%2 == 0, 1, 0, 0);
    check("t3_count_steady", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);
    check("t3_drained", 32'(count), 32'd0);

    // Resolve while empty: ignored
    check("t4_res_ready", 32'(res_ready), 32'd0);
    step(0, 8'h00, 0, 1, 0, 0);
    step(0, 8'h00, 0, 1, 1, 0);
    check("t4_count", 32'(count), 32'd0);

    // Flush coinciding with pop and push
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 1, 0, 0, 0);
    saved_cnt = mispredict_cnt;
    step(1, 8'h99, 0, 1, 0, 1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_pred_ready", 32'(pred_ready), 32'd1);
    check("t5_res_ready", 32'(res_ready), 32'd0);
    check("t5_no_upd", 32'(upd_enable), 32'd0);
    check("t5_mcnt_kept", 32'(mispredict_cnt), 32'(saved_cnt));
    step(1, 8'hAA, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0);
    @(posedge clk); #1;
    check("t5_aa_addr", 32'(upd_addr), 32'h0000_00AA);

    // Saturation from a clean reset: 17 mispredicts hold at 15
    rst_n = 1'b0;
    exp_q.delete(); mdl_q.delete(); mdl_cnt = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 8'h01, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(1, 8'(8'h02 + i), 1, 1, 0, 0);
    check("t6_sat", 32'(mispredict_cnt), 32'd15);
    check("t6_count", 32'(count), 32'd1);

    // Asynchronous reset mid-burst
    pred_valid = 1'b1; pred_addr = 8'h77; pred_taken = 1'b1;
    res_valid = 1'b1;  res_taken = 1'b0;
    @(posedge clk); #1;
    check("t6_burst_upd", 32'(upd_enable), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.delete(); mdl_q.delete(); mdl_cnt = '0;
    #1;
    check("ar_upd_enable", 32'(upd_enable), 32'd0);
    check("ar_mispredict", 32'(mispredict), 32'd0);
    check("ar_upd_addr", 32'(upd_addr), 32'd0);
    check("ar_upd_taken", 32'(upd_taken), 32'd0);
    check("ar_mcnt", 32'(mispredict_cnt), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_pred_ready", 32'(pred_ready), 32'd1);
    check("ar_res_ready", 32'(res_ready), 32'd0);
    pred_valid = 1'b0; res_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Update-side companion to the 256-entry 2-bit branch predictor table.
- Records every issued prediction (index, predicted direction) in program order. When the branch outcome resolves, it pops the oldest record and drives the table's update interface: index, actual taken, one-cycle update enable.
- Flags mispredictions to the front end and keeps a saturating mispredict counter for performance monitoring.

Parameters:
- ADDR_W, 8, predictor table index width; must match the table's addr width.
- DEPTH, 8, number of in-flight predictions tracked; power of two, at least 2.
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- pred_valid  input  1  a prediction was issued this cycle.
- pred_addr  input  ADDR_W  table index used for that prediction.
- pred_taken  input  1  predicted direction (1 = taken).
- pred_ready  output  1  queue can accept a record; equals !full.
- res_valid  input  1  oldest in-flight branch resolved this cycle.
- res_taken  input  1  actual outcome (1 = taken).
- res_ready  output  1  a record is available to resolve; equals !empty.
- flush  input  1  discard all in-flight records (pipeline squash).
- upd_enable  output  1  one-cycle strobe to the table's update enable.
- upd_addr  output  ADDR_W  table index to update.
- upd_taken  output  1  outcome to train with; drives the table's taken input.
- mispredict  output  1  one-cycle strobe; the resolved branch was mispredicted.
- count  output  log2(DEPTH)+1  current occupancy.
- mispredict_cnt  output  CNT_W  total mispredicts since reset, saturating.

Behaviour:
- Storage: circular buffer of DEPTH entries {addr, pred}. Write pointer and read pointer are log2(DEPTH) bits and wrap naturally. Occupancy is tracked in count.
- Push: pred_valid && pred_ready. Entry is written at the write pointer, the pointer advances, count increments.
- Pop: res_valid && res_ready. Head entry is consumed, the read pointer advances, count decrements.
- Simultaneous push and pop: both happen and count is unchanged.
  - When full, pred_ready=0, so the push is refused even if a pop occurs the same cycle. pred_ready is not combinationally dependent on res_valid.
  - When empty, res_ready=0, so res_valid is ignored and no update is produced. This is a protocol error by the front end; the block does not check it.
- Update outputs are registered; latency is 1 cycle from the pop edge. The cycle after a pop:
  - upd_enable=1, upd_addr=head addr, upd_taken=res_taken.
  - mispredict=(res_taken != head pred).
  - Otherwise upd_enable=0 and mispredict=0. upd_addr and upd_taken hold their last values.
- mispredict_cnt increments by 1 on each pop whose outcome differs from the prediction. It holds at 2^CNT_W-1 and never wraps. It updates on the same edge the mispredict strobe is registered.
- Flush has highest priority:
  - Pointers and count go to 0.
  - Any same-cycle push and pop are discarded; no update strobe follows.
  - mispredict_cnt is not cleared.
  - pred_ready=1 and res_ready=0 on the following cycle.
- Back-to-back pops on consecutive cycles give consecutive upd_enable pulses, one per pop, in FIFO order.
- Reset (asynchronous assert, any time including mid-stream): pointers=0, count=0, pred_ready=1, res_ready=0, upd_enable=0, upd_addr=0, upd_taken=0, mispredict=0, mispredict_cnt=0. Storage contents need not be reset.

Test Plan:
- Push {0x12,T},{0x34,N},{0x56,T}, then resolve T,T,T on consecutive cycles -> upd_enable pulses on 3 consecutive cycles with upd_addr 0x12,0x34,0x56. mispredict is 0,1,0. mispredict_cnt=1. count returns to 0.
- Push DEPTH=8 records -> pred_ready=0, count=8. A further pred_valid is ignored. Pop once with push asserted the same cycle -> push refused, count=7, pred_ready=1 next cycle.
- With count=3, push and pop in the same cycle 20 times across pointer wrap -> count stays 3, and upd_addr sequence matches push order exactly.
- res_valid=1 with queue empty -> res_ready=0 and no upd_enable or mispredict pulse.
- Push 4 records, then flush in the same cycle as a pop -> no upd_enable next cycle, count=0, mispredict_cnt unchanged. A fresh push of {0xAA,N} resolved N gives upd_addr=0xAA, mispredict=0.
- Force mispredict_cnt near saturation (CNT_W=4 build: 15 mispredicts, then 2 more) -> holds at 15. Assert rst_n=0 mid-burst asynchronously -> all outputs return to reset values before the next clk edge.
